// File: rtl/chunk_sequencer.sv
// chunk_sequencer: runs a job of N 512-bit blocks through the cipher core and the chunk divider,
// one block in flight at a time, with a watchdog on both core and divider waits.
module chunk_sequencer #(
    parameter int NBLK_W      = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic              chunk_seq_clk,
    input  logic              chunk_seq_reset,
    input  logic              start,
    input  logic              encryp_decryp,
    input  logic [NBLK_W-1:0] num_blocks,
    input  logic [255:0]      key_in,
    input  logic [63:0]       nonce_in,
    input  logic [63:0]       counter_in,
    input  logic [511:0]      blk_in_data,
    input  logic              blk_in_valid,
    output logic              blk_in_ready,
    output logic              core_start,
    output logic [255:0]      core_key,
    output logic [63:0]       core_nonce,
    output logic [63:0]       core_counter,
    output logic [511:0]      core_block_in,
    input  logic              core_done,
    input  logic [511:0]      core_block_out,
    output logic              div_valid,
    output logic              div_mode,
    output logic [255:0]      div_key,
    output logic [63:0]       div_nonce,
    output logic [63:0]       div_counter,
    output logic [511:0]      div_data,
    input  logic              div_last_byte,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [NBLK_W-1:0] blocks_done,
    output logic              ctr_wrap
);
    localparam int WD_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {IDLE, LOAD, CSTART, CWAIT, EMIT, DRAIN, FINISH, ABORT} state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [255:0]        key_q, key_d;
    logic [63:0]         nonce_q, nonce_d;
    logic [63:0]         ctr_q, ctr_d;
    logic [NBLK_W-1:0]   nblk_q, nblk_d;
    logic [NBLK_W-1:0]   bdone_q, bdone_d;
    logic [511:0]        blk_q, blk_d;
    logic [511:0]        res_q, res_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                err_q, err_d;
    logic                wrap_q, wrap_d;
    logic                wd_hit;
    logic [NBLK_W-1:0]   bdone_inc;

    assign wd_hit    = wd_q == WD_W'(TIMEOUT_CYC - 1);
    assign bdone_inc = bdone_q + NBLK_W'(1);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        key_d   = key_q;
        nonce_d = nonce_q;
        ctr_d   = ctr_q;
        nblk_d  = nblk_q;
        bdone_d = bdone_q;
        blk_d   = blk_q;
        res_d   = res_q;
        wd_d    = wd_q;
        err_d   = err_q;
        wrap_d  = wrap_q;
        case (state_q)
            IDLE: if (start) begin
                mode_d  = encryp_decryp;
                key_d   = key_in;
                nonce_d = nonce_in;
                ctr_d   = counter_in;
                nblk_d  = num_blocks;
                bdone_d = '0;
                wd_d    = '0;
                err_d   = 1'b0;
                wrap_d  = 1'b0;
                state_d = num_blocks == '0 ? FINISH : LOAD;
            end
            LOAD: if (blk_in_valid) begin
                blk_d   = blk_in_data;
                state_d = CSTART;
            end
            CSTART: begin
                wd_d    = '0;
                state_d = CWAIT;
            end
            CWAIT: if (core_done) begin
                res_d   = core_block_out;
                state_d = EMIT;
            end else if (wd_hit) begin
                err_d   = 1'b1;
                state_d = ABORT;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
            EMIT: begin
                wd_d    = '0;
                state_d = DRAIN;
            end
            DRAIN: if (div_last_byte) begin
                bdone_d = bdone_inc;
                if (bdone_inc == nblk_q) begin
                    state_d = FINISH;
                end else begin
                    // counter wraps modulo 2^64; the wrap is remembered for the job
                    ctr_d   = ctr_q + 64'd1;
                    wrap_d  = wrap_q | (&ctr_q);
                    state_d = LOAD;
                end
            end else if (wd_hit) begin
                err_d   = 1'b1;
                state_d = ABORT;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge chunk_seq_clk) begin
        if (chunk_seq_reset) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            key_q   <= '0;
            nonce_q <= '0;
            ctr_q   <= '0;
            nblk_q  <= '0;
            bdone_q <= '0;
            blk_q   <= '0;
            res_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            key_q   <= key_d;
            nonce_q <= nonce_d;
            ctr_q   <= ctr_d;
            nblk_q  <= nblk_d;
            bdone_q <= bdone_d;
            blk_q   <= blk_d;
            res_q   <= res_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
        end
    end

    assign blk_in_ready  = state_q == LOAD;
    assign core_start    = state_q == CSTART;
    assign div_valid     = state_q == EMIT;
    assign busy          = state_q != IDLE;
    assign done          = state_q == FINISH || state_q == ABORT;
    assign core_key      = key_q;
    assign core_nonce    = nonce_q;
    assign core_counter  = ctr_q;
    assign core_block_in = blk_q;
    assign div_mode      = mode_q;
    assign div_key       = key_q;
    assign div_nonce     = nonce_q;
    assign div_counter   = ctr_q;
    assign div_data      = res_q;
    assign err           = err_q;
    assign blocks_done   = bdone_q;
    assign ctr_wrap      = wrap_q;
endmodule
